// File: rtl/serial_alu_if.sv
// Handshake bundle between operand stage, serial_alu and writeback.
// The overflow signal exists only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef SERIAL_ALU_OVF_EN
    logic             overflow;

    modport master (output in_valid, dataA, dataB, Signal, out_ready,
                    input  in_ready, out_valid, result, zero, overflow);
    modport slave  (input  in_valid, dataA, dataB, Signal, out_ready,
                    output in_ready, out_valid, result, zero, overflow);
`else
    modport master (output in_valid, dataA, dataB, Signal, out_ready,
                    input  in_ready, out_valid, result, zero);
    modport slave  (input  in_valid, dataA, dataB, Signal, out_ready,
                    output in_ready, out_valid, result, zero);
`endif
endinterface

// File: rtl/serial_alu.sv
// Digit-serial ALU: WIDTH/DIGIT cycles per op (WIDTH > DIGIT), LSB digit first.
// Optional signed-overflow output enabled by SERIAL_ALU_OVF_EN.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_alu_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT} op_t;

    state_t           state, state_nx;
    op_t              op_q, op_dec;
    logic [WIDTH-1:0] a_q, b_q, res_q, final_res;
    logic [CW-1:0]    cnt;
    logic             carry, zero_q;
    logic             accept, last, in_ready, out_valid;
    logic             binv, ovf, less;
    logic [DIGIT-1:0] b_d, sum_d, dig_res;
    logic [DIGIT:0]   c;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q;
`endif

    always_comb begin
        case (bus.Signal)
            6'b100100: op_dec = OP_AND;
            6'b100101: op_dec = OP_OR;
            6'b100010: op_dec = OP_SUB;
            6'b101010: op_dec = OP_SLT;
            default:   op_dec = OP_ADD;
        endcase
    end

    assign binv = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign last = (cnt == CW'(N - 1));

    // Operands shift right each cycle, so the active digit is always the low DIGIT bits.
    always_comb begin
        b_d  = b_q[DIGIT-1:0] ^ {DIGIT{binv}};
        c    = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            sum_d[i] = a_q[i] ^ b_d[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_d[i]) | (c[i] & (a_q[i] ^ b_d[i]));
        end
        ovf  = (a_q[DIGIT-1] ~^ b_d[DIGIT-1]) & (sum_d[DIGIT-1] ^ a_q[DIGIT-1]);
        less = sum_d[DIGIT-1] ^ ovf;
        case (op_q)
            OP_AND:  dig_res = a_q[DIGIT-1:0] & b_q[DIGIT-1:0];
            OP_OR:   dig_res = a_q[DIGIT-1:0] | b_q[DIGIT-1:0];
            default: dig_res = sum_d;
        endcase
        final_res = {dig_res, res_q[WIDTH-1:DIGIT]};
        if (op_q == OP_SLT)
            final_res = {{(WIDTH-1){1'b0}}, less};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN:  if (last) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= OP_ADD;
            cnt    <= '0;
            carry  <= 1'b0;
            zero_q <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= bus.dataA;
            b_q   <= bus.dataB;
            op_q  <= op_dec;
            cnt   <= '0;
            carry <= (op_dec == OP_SUB) || (op_dec == OP_SLT);
        end else if (state == RUN) begin
            a_q   <= a_q >> DIGIT;
            b_q   <= b_q >> DIGIT;
            carry <= c[DIGIT];
            res_q <= final_res;
            if (last) begin
                cnt    <= '0;
                zero_q <= (final_res == '0);
`ifdef SERIAL_ALU_OVF_EN
                ovf_q  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? ovf : 1'b0;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
`ifdef SERIAL_ALU_OVF_EN
    assign bus.overflow  = ovf_q;
`endif
endmodule
